// File: rtl/core_seq_pkg.sv
// core_seq_pkg: shared state encoding and instruction bit positions for the layer sequencer.
package core_seq_pkg;
  typedef enum logic [2:0] {IDLE, WLOAD, GAP, EXEC, DRAIN, ACC} state_t;
  localparam int INST_ACC  = 33;
  localparam int INST_CEN  = 19;
  localparam int INST_WEN  = 18;
  localparam int INST_A_HI = 17;
  localparam int INST_A_LO = 7;
  localparam int INST_LOAD = 0;
endpackage

// File: rtl/core_seq_if.sv
// core_seq_if: host/core-facing signals of the layer sequencer; err exists only with CORE_SEQ_TIMEOUT_EN.
interface core_seq_if;
  logic        start;
  logic        ofifo_valid;
  logic [33:0] inst;
  logic [1:0]  inst_w;
  logic        busy;
  logic        done;
  logic [3:0]  kij_idx;
`ifdef CORE_SEQ_TIMEOUT_EN
  logic        err;
  modport master(output start, ofifo_valid, input inst, inst_w, busy, done, kij_idx, err);
  modport slave(input start, ofifo_valid, output inst, inst_w, busy, done, kij_idx, err);
`else
  modport master(output start, ofifo_valid, input inst, inst_w, busy, done, kij_idx);
  modport slave(input start, ofifo_valid, output inst, inst_w, busy, done, kij_idx);
`endif
endinterface

// File: rtl/seq_cnt.sv
// seq_cnt: loadable up-counter with clear, enable and terminal-count flag.
module seq_cnt #(
  parameter int w = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic         i_ld,
  input  logic [w-1:0] i_ld_val,
  input  logic [w-1:0] i_tc_val,
  output logic [w-1:0] o_cnt,
  output logic         o_tc
);
  logic [w-1:0] r_cnt;
  always_ff @(posedge clk)
    if (reset || i_clr) r_cnt <= '0;
    else if (i_ld) r_cnt <= i_ld_val;
    else if (i_en) r_cnt <= r_cnt + 1'b1;
  assign o_cnt = r_cnt;
  assign o_tc  = r_cnt == i_tc_val;
endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: runs one convolution layer (weight load, gap, execute, drain per kij, then accumulate).
// Define CORE_SEQ_TIMEOUT_EN to add a DRAIN watchdog that aborts to IDLE and pulses err.
module core_sequencer
  import core_seq_pkg::*;
#(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int nij_len = 3,
  parameter int kij_len = 9,
  parameter int gap_len = 16,
  parameter int w_base  = 0,
  parameter int a_base  = 1024
) (
  input logic       clk,
  input logic       reset,
  core_seq_if.slave bus
);
  localparam int pw = 10;
  state_t      r_state, w_next;
  logic [pw-1:0] w_ph, w_ph_last, w_vld;
  logic [3:0]  w_kij;
  logic        w_ph_tc, w_kij_tc, w_vld_tc, w_vld_en, w_kij_en, w_drain_ok, w_rd, w_wd_exp;
  logic [10:0] w_addr;
  logic [33:0] w_inst, r_inst;
  logic [1:0]  r_inst_w;
  logic        r_busy, r_done;
  logic [3:0]  r_kij;
  if (gap_len < row + col) begin : g_gap_below_array_skew
  end
  assign w_ph_last = r_state == WLOAD ? pw'(row - 1) :
                     r_state == GAP   ? pw'(gap_len - 1) :
                     r_state == EXEC  ? pw'(nij_len - 1) :
                     r_state == ACC   ? pw'(nij_len * kij_len - 1) : '0;
  seq_cnt #(.w(pw)) u_ph (
    .clk(clk), .reset(reset), .i_clr(w_next != r_state), .i_en(r_state != IDLE),
    .i_ld(1'b0), .i_ld_val('0), .i_tc_val(w_ph_last), .o_cnt(w_ph), .o_tc(w_ph_tc)
  );
  seq_cnt #(.w(4)) u_kij (
    .clk(clk), .reset(reset), .i_clr(w_next == IDLE), .i_en(w_kij_en),
    .i_ld(1'b0), .i_ld_val('0), .i_tc_val(4'(kij_len - 1)), .o_cnt(w_kij), .o_tc(w_kij_tc)
  );
  // psum arrivals count from the first cycle after the weights are in, never past nij_len
  assign w_vld_en = bus.ofifo_valid && !w_vld_tc && r_state inside {GAP, EXEC, DRAIN};
  seq_cnt #(.w(pw)) u_vld (
    .clk(clk), .reset(reset), .i_clr(w_next == WLOAD && r_state != WLOAD), .i_en(w_vld_en),
    .i_ld(1'b0), .i_ld_val('0), .i_tc_val(pw'(nij_len)), .o_cnt(w_vld), .o_tc(w_vld_tc)
  );
  assign w_drain_ok = w_vld_tc || (w_vld == pw'(nij_len - 1) && w_vld_en);
`ifdef CORE_SEQ_TIMEOUT_EN
  logic [9:0] w_wd;
  logic       w_wd_tc, r_err;
  seq_cnt #(.w(10)) u_wd (
    .clk(clk), .reset(reset), .i_clr(r_state != DRAIN), .i_en(1'b1),
    .i_ld(1'b0), .i_ld_val('0), .i_tc_val(10'h3ff), .o_cnt(w_wd), .o_tc(w_wd_tc)
  );
  assign w_wd_exp = r_state == DRAIN && w_wd_tc && !w_drain_ok;
  always_ff @(posedge clk) r_err <= !reset && w_wd_exp;
  assign bus.err = r_err;
`else
  assign w_wd_exp = 1'b0;
`endif
  always_ff @(posedge clk) r_state <= reset ? IDLE : w_next;
  always_comb begin
    w_next   = r_state;
    w_kij_en = 1'b0;
    unique case (r_state)
      IDLE:  w_next = bus.start ? WLOAD : IDLE;
      WLOAD: w_next = w_ph_tc ? GAP : WLOAD;
      GAP:   w_next = w_ph_tc ? EXEC : GAP;
      EXEC:  w_next = w_ph_tc ? DRAIN : EXEC;
      DRAIN: begin
        w_next   = !w_drain_ok ? DRAIN : w_kij_tc ? ACC : WLOAD;
        w_kij_en = w_drain_ok && !w_kij_tc;
      end
      ACC:     w_next = w_ph_tc ? IDLE : ACC;
      default: w_next = IDLE;
    endcase
    if (w_wd_exp) w_next = IDLE;
  end
  assign w_rd   = r_state inside {WLOAD, EXEC};
  assign w_addr = r_state == WLOAD ? 11'(w_base + int'(w_kij) * row + int'(w_ph)) : 11'(a_base + int'(w_ph));
  always_comb begin
    w_inst                      = '0;
    w_inst[INST_ACC]            = r_state == ACC;
    w_inst[INST_CEN]            = !w_rd;
    w_inst[INST_WEN]            = w_rd;
    w_inst[INST_A_HI:INST_A_LO] = w_rd ? w_addr : '0;
    w_inst[INST_LOAD]           = r_state == WLOAD;
  end
  always_ff @(posedge clk)
    if (reset) begin
      r_inst   <= 34'(1) << INST_CEN;
      r_inst_w <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_kij    <= '0;
    end else begin
      r_inst   <= w_inst;
      r_inst_w <= {r_state == EXEC, r_state == WLOAD};
      r_busy   <= r_state != IDLE;
      r_done   <= r_state == ACC && w_ph_tc;
      r_kij    <= w_kij;
    end
  assign bus.inst    = r_inst;
  assign bus.inst_w  = r_inst_w;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.kij_idx = r_kij;
endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: randomized psum arrivals against a cycle-level behavioural model of the layer schedule.
module tb_core_sequencer;
  localparam int ROW = 8, NIJ = 3, KIJ = 9, GAP = 16;
  localparam int S_IDLE = 0, S_WLOAD = 1, S_GAP = 2, S_EXEC = 3, S_DRAIN = 4, S_ACC = 5;
  logic clk = 1'b0, reset = 1'b1;
  core_seq_if bus();
  core_sequencer dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int n_w1 = 0, n_w2 = 0, n_acc = 0, n_done = 0;
  bit chk_en = 0, rnd = 0;
  int m_st = S_IDLE, m_n = 0, m_kij = 0, m_vld = 0;
  logic [33:0] e_inst;
  logic [1:0]  e_w;
  logic        e_busy, e_done;
  logic [3:0]  e_kij;

  function automatic logic [33:0] mk_inst(input int st, input int n, input int k);
    bit rd;
    int addr;
    rd   = st == S_WLOAD || st == S_EXEC;
    addr = st == S_WLOAD ? (ROW * k + n) % 2048 : st == S_EXEC ? (1024 + n) % 2048 : 0;
    return (34'(st == S_ACC) << 33) | (34'(!rd) << 19) | (34'(rd) << 18) | (34'(addr) << 7) | 34'(st == S_WLOAD);
  endfunction

  // outputs seen after an edge describe the schedule position held during the cycle before it
  always @(posedge clk) begin
    if (reset) begin
      m_st = S_IDLE; m_n = 0; m_kij = 0; m_vld = 0;
      e_inst = 34'h80000; e_w = 0; e_busy = 0; e_done = 0; e_kij = 0;
    end else begin
      e_inst = mk_inst(m_st, m_n, m_kij);
      e_w    = {m_st == S_EXEC, m_st == S_WLOAD};
      e_busy = m_st != S_IDLE;
      e_done = m_st == S_ACC && m_n == NIJ * KIJ - 1;
      e_kij  = 4'(m_kij);
      if (m_st >= S_GAP && m_st <= S_DRAIN && bus.ofifo_valid && m_vld < NIJ) m_vld++;
      m_n++;
      case (m_st)
        S_IDLE:  begin m_n = 0; if (bus.start) begin m_st = S_WLOAD; m_kij = 0; m_vld = 0; end end
        S_WLOAD: if (m_n == ROW) begin m_st = S_GAP; m_n = 0; end
        S_GAP:   if (m_n == GAP) begin m_st = S_EXEC; m_n = 0; end
        S_EXEC:  if (m_n == NIJ) begin m_st = S_DRAIN; m_n = 0; end
        S_DRAIN: begin
          m_n = 0;
          if (m_vld == NIJ) begin
            if (m_kij == KIJ - 1) m_st = S_ACC;
            else begin m_kij++; m_st = S_WLOAD; m_vld = 0; end
          end
        end
        default: if (m_n == NIJ * KIJ) begin m_st = S_IDLE; m_n = 0; m_kij = 0; end
      endcase
    end
  end

  always @(negedge clk) if (chk_en) begin
    total++;
    if (bus.inst !== e_inst || bus.inst_w !== e_w || bus.busy !== e_busy || bus.done !== e_done || bus.kij_idx !== e_kij) begin
      bad++;
      $display("FAIL cycle@%0t: inst=%h/%h inst_w=%b/%b busy=%b/%b done=%b/%b kij=%0d/%0d (got/want)",
               $time, bus.inst, e_inst, bus.inst_w, e_w, bus.busy, e_busy, bus.done, e_done, bus.kij_idx, e_kij);
    end
    n_w1   += int'(bus.inst_w == 2'b01);
    n_w2   += int'(bus.inst_w == 2'b10);
    n_acc  += int'(bus.inst[33]);
    n_done += int'(bus.done);
  end

  task automatic tick();
    @(negedge clk);
    if (rnd) bus.ofifo_valid = $urandom_range(0, 2) == 0;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_obs(input logic [3:0] k, input logic [1:0] w, input string nm);
    int i = 0;
    while (!(bus.kij_idx == k && bus.inst_w == w) && i < 4000) begin tick(); i++; end
    if (i == 4000) begin total++; bad++; $display("FAIL %s: timeout waiting kij=%0d inst_w=%b", nm, k, w); end
  endtask

  task automatic wait_done(input string nm);
    int i = 0;
    while (bus.done !== 1'b1 && i < 4000) begin tick(); i++; end
    if (i == 4000) begin total++; bad++; $display("FAIL %s: timeout waiting done", nm); end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.ofifo_valid = 1'b0;
    repeat (3) tick();
    chk_en = 1;
    reset = 1'b0;
    chk("reset_inst", bus.inst, 34'h80000);
    chk("reset_busy", bus.busy, 0);
    // layer 1: fixed opening, then random psum arrivals
    n_w1 = 0; n_w2 = 0; n_acc = 0; n_done = 0;
    pulse_start();
    tick();
    chk("wload_first", bus.inst, 34'h40001);
    chk("wload_mode", bus.inst_w, 2'b01);
    repeat (7) tick();
    chk("wload_last", bus.inst, 34'h40381);
    repeat (17) tick();
    chk("exec_first", bus.inst, 34'h60000);
    chk("exec_mode", bus.inst_w, 2'b10);
    rnd = 1;
    wait_done("layer1");
    repeat (2) tick();
    chk("l1_wload_cycles", n_w1, ROW * KIJ);
    chk("l1_exec_cycles", n_w2, NIJ * KIJ);
    chk("l1_acc_cycles", n_acc, NIJ * KIJ);
    chk("l1_done_pulses", n_done, 1);
    chk("l1_idle", bus.busy, 0);
    // layer 2: starve DRAIN, then a long valid burst
    rnd = 0;
    bus.ofifo_valid = 1'b0;
    pulse_start();
    wait_obs(0, 2'b10, "l2_exec");
    wait_obs(0, 2'b00, "l2_drain");
    repeat (200) tick();
    chk("drain_hold_busy", bus.busy, 1);
    chk("drain_hold_mode", bus.inst_w, 2'b00);
    chk("drain_hold_kij", bus.kij_idx, 0);
    bus.ofifo_valid = 1'b1;
    repeat (5) tick();
    bus.ofifo_valid = 1'b0;
    tick();
    chk("burst_kij", bus.kij_idx, 1);
    chk("burst_inst", bus.inst, 34'h40501);
    rnd = 1;
    wait_done("layer2");
    // layer 3: stray start during execute of kij 2
    tick();
    n_done = 0;
    pulse_start();
    wait_obs(2, 2'b10, "l3_exec2");
    pulse_start();
    wait_done("layer3");
    repeat (10) tick();
    chk("l3_single_done", n_done, 1);
    chk("l3_idle", bus.busy, 0);
    // layer 4: reset during weight load of kij 4, then restart
    pulse_start();
    wait_obs(4, 2'b01, "l4_wload4");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_inst", bus.inst, 34'h80000);
    chk("abort_kij", bus.kij_idx, 0);
    chk("abort_busy", bus.busy, 0);
    rnd = 0;
    bus.ofifo_valid = 1'b0;
    pulse_start();
    tick();
    chk("restart_inst", bus.inst, 34'h40001);
    chk("restart_kij", bus.kij_idx, 0);
    rnd = 1;
    wait_done("layer4");
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
